// File: rtl/mdu_ctrl.sv
// Multiply/divide unit controller: issues mult/div operations, models the
// busy period, and owns the architectural HI/LO registers.
module mdu_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  e_op,
    input  logic        e_valid,
    input  logic [31:0] e_a,
    input  logic [31:0] e_b,
    input  logic        d_is_md,
    output logic        busy,
    output logic        start,
    output logic        stall_md,
    output logic [31:0] md_out,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned PROD_W = 64;
    localparam int unsigned CNT_W  = 4;

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;

    logic [DATA_W-1:0] hi_q, hi_d;
    logic [DATA_W-1:0] lo_q, lo_d;
    logic [DATA_W-1:0] pend_hi_q, pend_hi_d;
    logic [DATA_W-1:0] pend_lo_q, pend_lo_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              busy_q, busy_d;

    logic                     is_muldiv;
    logic                     is_mult;
    logic                     div_by_zero;
    logic signed [DATA_W-1:0] a_s, b_s, b_safe_s;
    logic        [DATA_W-1:0] b_safe;
    logic signed [PROD_W-1:0] a_ext, b_ext, prod_s;
    logic        [PROD_W-1:0] prod_u;
    logic signed [DATA_W-1:0] quot_s, rem_s;
    logic        [DATA_W-1:0] quot_u, rem_u;

    // Datapath: full-width products and a zero-safe divisor to keep X out
    always_comb begin
        a_s         = e_a;
        b_s         = e_b;
        div_by_zero = (e_b == '0);
        b_safe      = div_by_zero ? DATA_W'(1) : e_b;
        b_safe_s    = b_safe;
        a_ext       = PROD_W'(a_s);
        b_ext       = PROD_W'(b_s);
        prod_s      = a_ext * b_ext;
        prod_u      = PROD_W'(e_a) * PROD_W'(e_b);
        quot_s      = a_s / b_safe_s;
        rem_s       = a_s % b_safe_s;
        quot_u      = e_a / b_safe;
        rem_u       = e_a % b_safe;
    end

    always_comb begin
        is_muldiv = (e_op == OP_MULT) || (e_op == OP_MULTU) ||
                    (e_op == OP_DIV)  || (e_op == OP_DIVU);
        is_mult   = (e_op == OP_MULT) || (e_op == OP_MULTU);
        start     = e_valid & is_muldiv & ~busy_q;
        stall_md  = d_is_md & (start | busy_q);
    end

    // Move-from reads only the committed registers, never an in-flight result
    always_comb begin
        md_out = '0;
        if (e_op == OP_MFHI) begin
            md_out = hi_q;
        end else if (e_op == OP_MFLO) begin
            md_out = lo_q;
        end
    end

    always_comb begin
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;

        if (busy_q) begin
            if (cnt_q == CNT_W'(1)) begin
                hi_d   = pend_hi_q;
                lo_d   = pend_lo_q;
                busy_d = 1'b0;
                cnt_d  = '0;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end else if (start) begin
            busy_d = 1'b1;
            cnt_d  = is_mult ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
            unique case (e_op)
                OP_MULT: begin
                    pend_hi_d = prod_s[PROD_W-1:DATA_W];
                    pend_lo_d = prod_s[DATA_W-1:0];
                end
                OP_MULTU: begin
                    pend_hi_d = prod_u[PROD_W-1:DATA_W];
                    pend_lo_d = prod_u[DATA_W-1:0];
                end
                OP_DIV: begin
                    // Divide by zero re-commits the current HI/LO unchanged
                    pend_hi_d = div_by_zero ? hi_q : rem_s;
                    pend_lo_d = div_by_zero ? lo_q : quot_s;
                end
                default: begin
                    pend_hi_d = div_by_zero ? hi_q : rem_u;
                    pend_lo_d = div_by_zero ? lo_q : quot_u;
                end
            endcase
        end else if (e_valid && (e_op == OP_MTHI)) begin
            hi_d = e_a;
        end else if (e_valid && (e_op == OP_MTLO)) begin
            lo_d = e_a;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
        end else begin
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
        end
    end

    assign busy = busy_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl: stimulus queues expected HI/LO and busy
// length per operation; a monitor checks them when busy falls.
module tb_mdu_ctrl;

    logic        clk;
    logic        reset;
    logic [3:0]  e_op;
    logic        e_valid;
    logic [31:0] e_a;
    logic [31:0] e_b;
    logic        d_is_md;
    logic        busy;
    logic        start;
    logic        stall_md;
    logic [31:0] md_out;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        string       name;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
    } exp_t;

    exp_t sb[$];

    mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk      (clk),
        .reset    (reset),
        .e_op     (e_op),
        .e_valid  (e_valid),
        .e_a      (e_a),
        .e_b      (e_b),
        .d_is_md  (d_is_md),
        .busy     (busy),
        .start    (start),
        .stall_md (stall_md),
        .md_out   (md_out),
        .hi       (hi),
        .lo       (lo)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: one scoreboard entry is consumed per completed mult/div
    initial begin : monitor
        int   run;
        bit   prev;
        exp_t e;
        run  = 0;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                run  = 0;
                prev = 1'b0;
            end else begin
                if (busy) begin
                    run++;
                end else if (prev) begin
                    if (sb.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL unexpected_completion: got hi=0x%08h lo=0x%08h with empty queue", hi, lo);
                    end else begin
                        e = sb.pop_front();
                        chk({e.name, "_hi"}, hi, e.hi);
                        chk({e.name, "_lo"}, lo, e.lo);
                        chk({e.name, "_busy_cycles"}, 32'(run), 32'(e.cycles));
                    end
                    run = 0;
                end
                prev = busy;
            end
        end
    end

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        e_op    = op;
        e_valid = 1'b1;
        e_a     = a;
        e_b     = b;
    endtask

    task automatic idle_inputs();
        e_op    = 4'd0;
        e_valid = 1'b0;
        e_a     = 32'd0;
        e_b     = 32'd0;
    endtask

    task automatic wait_idle(input string name, input bit check_stall);
        int n;
        n = 0;
        while (busy && n < 40) begin
            if (check_stall) chk({name, "_stall_busy"}, 32'(stall_md), 32'd1);
            @(posedge clk);
            #1;
            n++;
        end
        if (busy) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s_timeout: got busy=1 after %0d cycles expected busy=0", name, n);
        end
    endtask

    // mode 0: plain; mode 1: check stall_md while busy; mode 2: inject mtlo/mult while busy
    task automatic issue(input string name, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_hi,
                         input logic [31:0] exp_lo, input int cycles, input int mode);
        exp_t e;
        drive(op, a, b);
        #1;
        chk({name, "_start"}, 32'(start), 32'd1);
        if (mode == 1) chk({name, "_stall_start"}, 32'(stall_md), 32'd1);
        e.name   = name;
        e.hi     = exp_hi;
        e.lo     = exp_lo;
        e.cycles = cycles;
        sb.push_back(e);
        @(posedge clk);
        #1;
        idle_inputs();
        if (mode == 2) begin
            drive(4'd6, 32'hDEADBEEF, 32'd0);
            @(posedge clk);
            #1;
            drive(4'd1, 32'd9, 32'd9);
            #1;
            chk({name, "_start_while_busy"}, 32'(start), 32'd0);
            @(posedge clk);
            #1;
            idle_inputs();
        end
        wait_idle(name, mode == 1);
    endtask

    initial begin : stim
        reset   = 1'b0;
        d_is_md = 1'b0;
        idle_inputs();

        // Held in reset: registers cleared, start still follows its equation
        @(posedge clk);
        #1;
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        drive(4'd1, 32'd3, 32'd3);
        #1;
        chk("rst_start_comb", 32'(start), 32'd1);
        @(posedge clk);
        #1;
        chk("rst_busy_held", 32'(busy), 32'd0);
        idle_inputs();
        reset = 1'b1;

        issue("mult",  4'd1, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA, 5, 0);
        issue("multu", 4'd2, 32'hFFFFFFFE, 32'd3, 32'h00000002, 32'hFFFFFFFA, 5, 0);
        issue("div",   4'd3, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 10, 0);
        issue("divu0", 4'd4, 32'd7, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFD, 10, 0);
        issue("div_negb", 4'd3, 32'd7, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10, 0);

        drive(4'd5, 32'h12345678, 32'd0);
        #1;
        chk("mthi_start", 32'(start), 32'd0);
        @(posedge clk);
        #1;
        idle_inputs();
        chk("mthi_hi", hi, 32'h12345678);
        chk("mthi_lo_kept", lo, 32'hFFFFFFFD);
        chk("mthi_busy", 32'(busy), 32'd0);
        e_op = 4'd7;
        #1;
        chk("mfhi_md_out", md_out, 32'h12345678);
        e_op = 4'd0;
        #1;
        chk("none_md_out", md_out, 32'd0);

        drive(4'd6, 32'hCAFEF00D, 32'd0);
        @(posedge clk);
        #1;
        idle_inputs();
        chk("mtlo_lo", lo, 32'hCAFEF00D);

        issue("mult_inject", 4'd1, 32'd100, 32'd7, 32'd0, 32'h000002BC, 5, 2);

        d_is_md = 1'b1;
        issue("divu_stall", 4'd4, 32'd100, 32'd7, 32'd2, 32'd14, 10, 1);
        chk("stall_released", 32'(stall_md), 32'd0);
        drive(4'd8, 32'd0, 32'd0);
        #1;
        chk("mflo_after_busy", md_out, 32'd14);
        idle_inputs();
        d_is_md = 1'b0;

        e_op = 4'd1;
        e_valid = 1'b0;
        e_a = 32'd5;
        e_b = 32'd5;
        #1;
        chk("nvalid_start", 32'(start), 32'd0);
        @(posedge clk);
        #1;
        idle_inputs();
        chk("nvalid_busy", 32'(busy), 32'd0);
        chk("nvalid_hi", hi, 32'd2);
        chk("nvalid_lo", lo, 32'd14);

        // Reset during the third busy cycle of a div aborts it
        drive(4'd3, 32'd100, 32'd7);
        @(posedge clk);
        #1;
        idle_inputs();
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_hi", hi, 32'd0);
        chk("abort_lo", lo, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        issue("mult_after_rst", 4'd1, 32'h00010000, 32'h00010000, 32'd1, 32'd0, 5, 0);

        @(posedge clk);
        @(posedge clk);
        #1;
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
